// File: rtl/local_two_level_predictor.sv
// Local two-level branch predictor: per-PC history table (flops) indexes a PHT of saturating counters.
// Optional macro LOCAL_TWO_LEVEL_PREDICTOR_WRITE_BYPASS_EN forwards same-cycle granted PHT writes to reads.
module local_two_level_predictor #(
    parameter int FETCH_WIDTH  = 2,
    parameter int UPD_WIDTH    = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int INSN_LSB     = 2,
    parameter int BHT_IDX_BITS = 6,
    parameter int HIST_BITS    = 6,
    parameter int PHT_PC_BITS  = 2,
    parameter int CTR_BITS     = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            stall,
    input  logic                            req_valid,
    input  logic [ADDR_WIDTH-1:0]           req_pc,
    input  logic [FETCH_WIDTH-1:0]          btb_hit,
    input  logic [FETCH_WIDTH-1:0]          is_cond_br,
    output logic                            pred_valid,
    output logic [FETCH_WIDTH-1:0]          pred_taken,
    output logic [FETCH_WIDTH*HIST_BITS-1:0] pred_hist,
    output logic [FETCH_WIDTH*CTR_BITS-1:0] pred_ctr,
    output logic                            ready,
    input  logic [UPD_WIDTH-1:0]            upd_valid,
    input  logic [UPD_WIDTH-1:0]            upd_taken,
    input  logic [UPD_WIDTH-1:0]            upd_mispred,
    input  logic [UPD_WIDTH*ADDR_WIDTH-1:0] upd_pc,
    input  logic [UPD_WIDTH*HIST_BITS-1:0]  upd_hist,
    input  logic [UPD_WIDTH*CTR_BITS-1:0]   upd_ctr
);
    localparam int PHT_IDX_BITS = HIST_BITS + PHT_PC_BITS;
    localparam int PHT_DEPTH    = 1 << PHT_IDX_BITS;
    localparam int BHT_DEPTH    = 1 << BHT_IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b1, {(CTR_BITS-1){1'b0}}};

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                                       r_state, w_state_nxt;
    logic [PHT_IDX_BITS-1:0]                      r_init_idx, w_init_idx_nxt;
    logic                                         w_ready;
    logic [BHT_DEPTH-1:0][HIST_BITS-1:0]          r_bht, w_bht_nxt;
    logic [CTR_BITS-1:0]                          r_pht [PHT_DEPTH];

    logic [FETCH_WIDTH-1:0][ADDR_WIDTH-1:0]       w_slot_pc;
    logic [FETCH_WIDTH-1:0][BHT_IDX_BITS-1:0]     w_slot_bht_idx;
    logic [FETCH_WIDTH-1:0][HIST_BITS-1:0]        w_slot_hist;
    logic [FETCH_WIDTH-1:0][PHT_IDX_BITS-1:0]     w_rd_idx;
    logic [FETCH_WIDTH-1:0][CTR_BITS-1:0]         w_rd_dat;
    logic                                         w_accept;

    logic                                         r_pred_valid;
    logic [FETCH_WIDTH-1:0][HIST_BITS-1:0]        r_pred_hist;
    logic [FETCH_WIDTH-1:0][CTR_BITS-1:0]         r_pred_ctr;
    logic [FETCH_WIDTH-1:0][BHT_IDX_BITS-1:0]     r_pred_bht_idx;
    logic [FETCH_WIDTH-1:0]                       w_pred_taken;
    logic                                         w_spec_blocked;

    logic [UPD_WIDTH-1:0][ADDR_WIDTH-1:0]         w_upd_pc;
    logic [UPD_WIDTH-1:0][HIST_BITS-1:0]          w_upd_hist;
    logic [UPD_WIDTH-1:0][CTR_BITS-1:0]           w_upd_ctr;
    logic [UPD_WIDTH-1:0][PHT_IDX_BITS-1:0]       w_wr_idx;
    logic [UPD_WIDTH-1:0][CTR_BITS-1:0]           w_wr_dat;
    logic [UPD_WIDTH-1:0]                         w_wr_en;
    logic                                         w_unused_pc;

    // FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_idx <= w_init_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_idx_nxt = r_init_idx;
        w_ready        = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_idx_nxt = r_init_idx + 1'b1;
                if (&r_init_idx) w_state_nxt = ST_RUN;
            end
            ST_RUN:  w_ready = 1'b1;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    assign ready    = w_ready;
    assign w_accept = req_valid & w_ready & ~stall;

    // Prediction lookup
    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_slot_pc[i]      = req_pc + (ADDR_WIDTH'(i) << INSN_LSB);
            w_slot_bht_idx[i] = w_slot_pc[i][INSN_LSB +: BHT_IDX_BITS];
            w_slot_hist[i]    = r_bht[w_slot_bht_idx[i]];
            w_rd_idx[i]       = {w_slot_hist[i], w_slot_pc[i][INSN_LSB +: PHT_PC_BITS]};
        end
    end

    // Update port decode; on equal PHT index the lowest-numbered port wins.
    always_comb begin
        for (int k = 0; k < UPD_WIDTH; k++) begin
            w_upd_pc[k]   = upd_pc[k*ADDR_WIDTH +: ADDR_WIDTH];
            w_upd_hist[k] = upd_hist[k*HIST_BITS +: HIST_BITS];
            w_upd_ctr[k]  = upd_ctr[k*CTR_BITS +: CTR_BITS];
            w_wr_idx[k]   = {w_upd_hist[k], w_upd_pc[k][INSN_LSB +: PHT_PC_BITS]};
            if (upd_taken[k])
                w_wr_dat[k] = (w_upd_ctr[k] == CTR_MAX) ? CTR_MAX : w_upd_ctr[k] + 1'b1;
            else
                w_wr_dat[k] = (w_upd_ctr[k] == '0) ? '0 : w_upd_ctr[k] - 1'b1;
        end
        for (int k = 0; k < UPD_WIDTH; k++) begin
            w_wr_en[k] = (r_state == ST_RUN) && upd_valid[k];
            for (int j = 0; j < k; j++)
                if (upd_valid[j] && (w_wr_idx[j] == w_wr_idx[k])) w_wr_en[k] = 1'b0;
        end
        if (r_state == ST_INIT) begin
            w_wr_en[0]  = 1'b1;
            w_wr_idx[0] = r_init_idx;
            w_wr_dat[0] = CTR_INIT;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < UPD_WIDTH; k++)
            if (w_wr_en[k]) r_pht[w_wr_idx[k]] <= w_wr_dat[k];
    end

`ifdef LOCAL_TWO_LEVEL_PREDICTOR_WRITE_BYPASS_EN
    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_rd_dat[i] = r_pht[w_rd_idx[i]];
            for (int k = 0; k < UPD_WIDTH; k++)
                if (w_wr_en[k] && (w_wr_idx[k] == w_rd_idx[i])) w_rd_dat[i] = w_wr_dat[k];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++)
            w_rd_dat[i] = r_pht[w_rd_idx[i]];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pred_valid   <= 1'b0;
            r_pred_hist    <= '0;
            r_pred_ctr     <= '0;
            r_pred_bht_idx <= '0;
        end else if (!stall) begin
            r_pred_valid <= w_accept;
            if (w_accept) begin
                r_pred_hist    <= w_slot_hist;
                r_pred_ctr     <= w_rd_dat;
                r_pred_bht_idx <= w_slot_bht_idx;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++)
            w_pred_taken[i] = r_pred_valid & r_pred_ctr[i][CTR_BITS-1] & btb_hit[i];
    end

    assign pred_valid = r_pred_valid;
    assign pred_taken = w_pred_taken;
    assign pred_hist  = r_pred_hist;
    assign pred_ctr   = r_pred_ctr;

    // Speculative shifts chain through w_bht_nxt; mispredict recovery is applied last so it wins.
    always_comb begin
        w_bht_nxt      = r_bht;
        w_spec_blocked = 1'b0;
        if (r_pred_valid && !stall) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (!w_spec_blocked && btb_hit[i] && is_cond_br[i])
                    w_bht_nxt[r_pred_bht_idx[i]] =
                        {w_bht_nxt[r_pred_bht_idx[i]][HIST_BITS-2:0], w_pred_taken[i]};
                if (w_pred_taken[i]) w_spec_blocked = 1'b1;
            end
        end
        if (r_state == ST_RUN) begin
            for (int k = 0; k < UPD_WIDTH; k++)
                if (upd_valid[k] && upd_mispred[k])
                    w_bht_nxt[w_upd_pc[k][INSN_LSB +: BHT_IDX_BITS]] =
                        {w_upd_hist[k][HIST_BITS-2:0], upd_taken[k]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_bht <= '0;
        else     r_bht <= w_bht_nxt;
    end

    assign w_unused_pc = ^{w_slot_pc, w_upd_pc};

endmodule

// File: tb/tb_local_two_level_predictor.sv
// Directed bench for local_two_level_predictor: init timing, prediction table, update/recovery/stall/bypass corners.
module tb_local_two_level_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        req_valid;
    logic [31:0] req_pc;
    logic [1:0]  btb_hit;
    logic [1:0]  is_cond_br;
    logic        pred_valid;
    logic [1:0]  pred_taken;
    logic [11:0] pred_hist;
    logic [3:0]  pred_ctr;
    logic        ready;
    logic [1:0]  upd_valid;
    logic [1:0]  upd_taken;
    logic [1:0]  upd_mispred;
    logic [63:0] upd_pc;
    logic [11:0] upd_hist;
    logic [3:0]  upd_ctr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  btb;
        logic [1:0]  cond;
        logic [1:0]  taken;
        logic [11:0] hist;
        logic [3:0]  ctr;
    } vec_t;

    vec_t tbl[6];

    local_two_level_predictor dut (
        .clk(clk), .rst(rst), .stall(stall), .req_valid(req_valid), .req_pc(req_pc),
        .btb_hit(btb_hit), .is_cond_br(is_cond_br), .pred_valid(pred_valid),
        .pred_taken(pred_taken), .pred_hist(pred_hist), .pred_ctr(pred_ctr), .ready(ready),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_mispred(upd_mispred),
        .upd_pc(upd_pc), .upd_hist(upd_hist), .upd_ctr(upd_ctr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic [1:0] v, input logic [1:0] tk, input logic [1:0] mp,
                           input logic [31:0] pc0, input logic [5:0] h0, input logic [1:0] c0,
                           input logic [31:0] pc1, input logic [5:0] h1, input logic [1:0] c1);
        upd_valid = v; upd_taken = tk; upd_mispred = mp;
        upd_pc = {pc1, pc0}; upd_hist = {h1, h0}; upd_ctr = {c1, c0};
    endtask

    task automatic clear_upd();
        set_upd(2'b00, 2'b00, 2'b00, 32'h0, 6'h0, 2'b00, 32'h0, 6'h0, 2'b00);
    endtask

    // Request in this cycle, then present the branch info aligned with pred_valid.
    task automatic predict(input logic [31:0] pc, input logic [1:0] btb, input logic [1:0] cond);
        req_valid = 1'b1; req_pc = pc;
        tick();
        req_valid = 1'b0; btb_hit = btb; is_cond_br = cond;
        #1;
    endtask

    task automatic finish_pred();
        tick();
        btb_hit = 2'b00; is_cond_br = 2'b00;
    endtask

    task automatic check_init(input string tag);
        repeat (255) tick();
        chk({tag, "_ready_low_after_255"}, {31'd0, ready}, 32'd0);
        tick();
        chk({tag, "_ready_high_after_256"}, {31'd0, ready}, 32'd1);
    endtask

    task automatic read_check(input string tag, input logic [11:0] hist, input logic [3:0] ctr);
        predict(32'h100, 2'b00, 2'b00);
        chk({tag, "_hist"}, {20'd0, pred_hist}, {20'd0, hist});
        chk({tag, "_ctr"}, {28'd0, pred_ctr}, {28'd0, ctr});
        finish_pred();
    endtask

    initial begin
        tbl[0] = '{32'h100, 2'b00, 2'b00, 2'b00, 12'h000, 4'b1010};
        tbl[1] = '{32'h100, 2'b10, 2'b10, 2'b10, 12'h000, 4'b1010};
        tbl[2] = '{32'h100, 2'b01, 2'b00, 2'b01, 12'h040, 4'b1010};
        tbl[3] = '{32'h108, 2'b01, 2'b01, 2'b01, 12'h000, 4'b1010};
        tbl[4] = '{32'h108, 2'b00, 2'b00, 2'b00, 12'h001, 4'b1010};
        tbl[5] = '{32'h1FC, 2'b11, 2'b00, 2'b11, 12'h000, 4'b1010};

        rst = 1'b1; stall = 1'b0; req_valid = 1'b0; req_pc = 32'h0;
        btb_hit = 2'b11; is_cond_br = 2'b00;
        clear_upd();
        #1;
        chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("rst_pred_taken", {30'd0, pred_taken}, 32'd0);
        chk("rst_pred_hist", {20'd0, pred_hist}, 32'd0);
        chk("rst_pred_ctr", {28'd0, pred_ctr}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        tick(); tick();
        rst = 1'b0;

        // Requests during INIT are ignored; reset at index 100 restarts the sweep.
        req_valid = 1'b1; req_pc = 32'h100; btb_hit = 2'b00;
        repeat (100) tick();
        chk("init_req_ignored", {31'd0, pred_valid}, 32'd0);
        chk("init_ready_low_100", {31'd0, ready}, 32'd0);
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_init("restart");

        for (int i = 0; i < 6; i++) begin
            predict(tbl[i].pc, tbl[i].btb, tbl[i].cond);
            chk($sformatf("vec%0d_valid", i), {31'd0, pred_valid}, 32'd1);
            chk($sformatf("vec%0d_taken", i), {30'd0, pred_taken}, {30'd0, tbl[i].taken});
            chk($sformatf("vec%0d_hist", i), {20'd0, pred_hist}, {20'd0, tbl[i].hist});
            chk($sformatf("vec%0d_ctr", i), {28'd0, pred_ctr}, {28'd0, tbl[i].ctr});
            finish_pred();
            chk($sformatf("vec%0d_valid_drop", i), {31'd0, pred_valid}, 32'd0);
        end

        // Same PHT index on both ports: port 0 wins.
        set_upd(2'b11, 2'b11, 2'b00, 32'h104, 6'h01, 2'b11, 32'h104, 6'h01, 2'b01);
        tick(); clear_upd();
        read_check("upd_dup_taken", 12'h040, 4'b1110);
        set_upd(2'b11, 2'b00, 2'b00, 32'h104, 6'h01, 2'b00, 32'h104, 6'h01, 2'b11);
        tick(); clear_upd();
        read_check("upd_dup_nt", 12'h040, 4'b0010);
        set_upd(2'b11, 2'b10, 2'b00, 32'h104, 6'h01, 2'b10, 32'h100, 6'h00, 2'b10);
        tick(); clear_upd();
        read_check("upd_two_idx", 12'h040, 4'b0111);

        // Slot 0 taken stops slot 1 from shifting its history.
        predict(32'h100, 2'b11, 2'b11);
        chk("first_taken_taken", {30'd0, pred_taken}, 32'd1);
        chk("first_taken_ctr", {28'd0, pred_ctr}, 32'h7);
        finish_pred();
        read_check("first_taken_after", 12'h041, 4'b0110);

        // Recovery overrides a same-cycle speculative shift of the same entry.
        predict(32'h100, 2'b10, 2'b10);
        chk("recov_pred_taken", {30'd0, pred_taken}, 32'd0);
        set_upd(2'b01, 2'b00, 2'b01, 32'h104, 6'b101010, 2'b10, 32'h0, 6'h0, 2'b00);
        finish_pred(); clear_upd();
        read_check("recov_vs_spec", 12'h501, 4'b1010);

        // Both ports recover the same entry: port 1 wins.
        set_upd(2'b11, 2'b10, 2'b11, 32'h104, 6'b101010, 2'b10, 32'h104, 6'b000111, 2'b10);
        tick(); clear_upd();
        read_check("recov_prio", 12'h3C1, 4'b1010);

        // Stall holds outputs, blocks new requests and speculative shifts.
        predict(32'h100, 2'b10, 2'b10);
        stall = 1'b1; req_valid = 1'b1; req_pc = 32'h108;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d_valid", c), {31'd0, pred_valid}, 32'd1);
            chk($sformatf("stall%0d_taken", c), {30'd0, pred_taken}, 32'd2);
            chk($sformatf("stall%0d_hist", c), {20'd0, pred_hist}, 32'h3C1);
            chk($sformatf("stall%0d_ctr", c), {28'd0, pred_ctr}, 32'hA);
        end
        stall = 1'b0; req_valid = 1'b0; btb_hit = 2'b00; is_cond_br = 2'b00;
        tick();
        chk("stall_release_valid", {31'd0, pred_valid}, 32'd0);
        read_check("stall_bht_kept", 12'h3C1, 4'b1010);

        // Read and write the same PHT index in one cycle.
        req_valid = 1'b1; req_pc = 32'h148;
        set_upd(2'b01, 2'b01, 2'b00, 32'h148, 6'h00, 2'b10, 32'h0, 6'h0, 2'b00);
        tick();
        req_valid = 1'b0; clear_upd();
        #1;
`ifdef LOCAL_TWO_LEVEL_PREDICTOR_WRITE_BYPASS_EN
        chk("same_cycle_rw_ctr", {28'd0, pred_ctr}, 32'hB);
`else
        chk("same_cycle_rw_ctr", {28'd0, pred_ctr}, 32'hA);
`endif
        finish_pred();
        predict(32'h148, 2'b00, 2'b00);
        chk("after_rw_ctr", {28'd0, pred_ctr}, 32'hB);
        chk("after_rw_hist", {20'd0, pred_hist}, 32'h0);
        finish_pred();

        // Reset with a prediction in flight drops it.
        req_valid = 1'b1; req_pc = 32'h100;
        tick();
        req_valid = 1'b0; btb_hit = 2'b11;
        chk("inflight_valid", {31'd0, pred_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_valid", {31'd0, pred_valid}, 32'd0);
        chk("midrun_rst_taken", {30'd0, pred_taken}, 32'd0);
        chk("midrun_rst_hist", {20'd0, pred_hist}, 32'd0);
        chk("midrun_rst_ctr", {28'd0, pred_ctr}, 32'd0);
        chk("midrun_rst_ready", {31'd0, ready}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("midrun_post_valid", {31'd0, pred_valid}, 32'd0);
        chk("midrun_post_ready", {31'd0, ready}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
